// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake and tag sideband.
// Barrel levels are spread over STAGES register stages; the last stage is the output register.
module pipelined_shift_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NI    = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Intermediate stage registers; amt holds only the not-yet-consumed amount bits, LSB-aligned
  logic [NI-1:0][WIDTH-1:0] val_q, val_d;
  logic [NI-1:0][LOG2W-1:0] amt_q, amt_d;
  logic [NI-1:0][2:0]       op_q, op_d;
  logic [NI-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NI-1:0]            vld_q, vld_d;
  logic [NI-1:0]            ovr_q, ovr_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             ovld_q, ovld_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic adv;

  assign adv         = !ovld_q || out_ready;
  assign in_ready    = adv;
  assign out_valid   = ovld_q;
  assign out_result  = res_q;
  assign out_tag     = otag_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] v,
                                                   input logic [2:0] op,
                                                   input int k);
    int n;
    logic [WIDTH-1:0] r;
    n = 1 << k;
    case (op)
      OP_SLL:  r = v << n;
      OP_SRL:  r = v >> n;
      OP_SRA:  r = $signed(v) >>> n;
      OP_ROL:  r = (v << n) | (v >> (WIDTH - n));
      OP_ROR:  r = (v >> n) | (v << (WIDTH - n));
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [WIDTH-1:0] v;
    logic [LOG2W-1:0] amt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tg;
    logic             vl;
    logic             ovr;
    logic             ill;
    int               prv;
    int               cur;

    val_d  = val_q;
    amt_d  = amt_q;
    op_d   = op_q;
    tag_d  = tag_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    res_d  = res_q;
    otag_d = otag_q;
    ovld_d = ovld_q;
    zero_d = zero_q;
    ill_d  = ill_q;
    v      = '0;
    amt    = '0;
    op     = '0;
    tg     = '0;
    vl     = 1'b0;
    ovr    = 1'b0;
    ill    = 1'b0;
    prv    = 0;
    cur    = 0;

    if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        prv = (s == 0) ? 0 : s - 1;
        cur = (s < NI) ? s : 0;
        if (s == 0) begin
          v   = in_a;
          amt = in_b[LOG2W-1:0];
          op  = in_op;
          tg  = in_tag;
          vl  = in_valid;
          ovr = |in_b[WIDTH-1:LOG2W];
        end else begin
          v   = val_q[prv];
          amt = amt_q[prv];
          op  = op_q[prv];
          tg  = tag_q[prv];
          vl  = vld_q[prv];
          ovr = ovr_q[prv];
        end

        for (int k = 0; k < LOG2W; k++) begin
          if ((k * STAGES) / LOG2W == s) begin
            if (amt[0]) v = shift_level(v, op, k);
            amt = amt >> 1;
          end
        end

        if (s == STAGES - 1) begin
          // SRA keeps the original sign in the MSB through every level, so it can seed the fill
          ill = (op > OP_ROR);
          if (ill) v = '0;
          else if (ovr && (op == OP_SLL || op == OP_SRL)) v = '0;
          else if (ovr && op == OP_SRA) v = {WIDTH{v[WIDTH-1]}};
          res_d  = v;
          otag_d = tg;
          ovld_d = vl;
          zero_d = (v == '0);
          ill_d  = ill;
        end else begin
          val_d[cur] = v;
          amt_d[cur] = amt;
          op_d[cur]  = op;
          tag_d[cur] = tg;
          vld_d[cur] = vl;
          ovr_d[cur] = ovr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      amt_q  <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      vld_q  <= '0;
      ovr_q  <= '0;
      res_q  <= '0;
      otag_q <= '0;
      ovld_q <= 1'b0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      val_q  <= val_d;
      amt_q  <= amt_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      res_q  <= res_d;
      otag_q <= otag_d;
      ovld_q <= ovld_d;
      zero_q <= zero_d;
      ill_q  <= ill_d;
    end
  end

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit: three instances (STAGES 2, 1, 5) exercised one at a time.
// Expected results come from an arithmetic reference model of the shift/rotate rules.
module tb_pipelined_shift_unit;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct {
    int          d;
    logic [31:0] res;
    logic [4:0]  tag;
    logic        zero;
    logic        ill;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        iv[3];
  logic        ir[3];
  logic        ov[3];
  logic        ordy[3];
  logic        oz[3];
  logic        oi[3];
  logic [31:0] ia[3];
  logic [31:0] ib[3];
  logic [31:0] ores[3];
  logic [2:0]  iop[3];
  logic [4:0]  itag[3];
  logic [4:0]  otag[3];

  int   stg[3] = '{2, 1, 5};
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic        held[3];
  logic [31:0] h_res[3];
  logic [4:0]  h_tag[3];
  logic        h_z[3];
  logic        h_i[3];

  pipelined_shift_unit #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_s2 (
    .clk(clk), .rst(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .in_op(iop[0]), .in_tag(itag[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_result(ores[0]), .out_tag(otag[0]), .out_zero(oz[0]), .out_illegal(oi[0]));

  pipelined_shift_unit #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_s1 (
    .clk(clk), .rst(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .in_op(iop[1]), .in_tag(itag[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_result(ores[1]), .out_tag(otag[1]), .out_zero(oz[1]), .out_illegal(oi[1]));

  pipelined_shift_unit #(.WIDTH(32), .STAGES(5), .TAG_W(5)) u_s5 (
    .clk(clk), .rst(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
    .in_op(iop[2]), .in_tag(itag[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_result(ores[2]), .out_tag(otag[2]), .out_zero(oz[2]), .out_illegal(oi[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int d, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [4:0] tag,
                                 input int acc, input bit lat);
    exp_t e;
    logic [63:0] dbl;
    int r;
    r     = int'(b % 32);
    e.d   = d;
    e.tag = tag;
    e.acc = acc;
    e.lat = lat;
    e.ill = 1'b0;
    case (op)
      OP_SLL: e.res = (b >= 32) ? 32'h0 : a << b[4:0];
      OP_SRL: e.res = (b >= 32) ? 32'h0 : a >> b[4:0];
      OP_SRA: e.res = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      OP_ROL: begin dbl = {a, a} << r; e.res = dbl[63:32]; end
      OP_ROR: begin dbl = {a, a} >> r; e.res = dbl[31:0]; end
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Monitor: retire checks, stall stability and in_ready behaviour for every instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (held[d]) begin
          chk("hold_result", ores[d], h_res[d]);
          chk("hold_tag", otag[d], h_tag[d]);
          chk("hold_flags", {oz[d], oi[d]}, {h_z[d], h_i[d]});
        end
        if (ov[d] && !ordy[d]) chk("stall_in_ready", ir[d], 0);
        if (!ov[d]) chk("idle_in_ready", ir[d], 1);
        held[d]  = ov[d] && !ordy[d];
        h_res[d] = ores[d];
        h_tag[d] = otag[d];
        h_z[d]   = oz[d];
        h_i[d]   = oi[d];
        if (ov[d] && ordy[d]) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", ov[d], 0);
          end else begin
            e = sb.pop_front();
            chk("dut_id", d, e.d);
            chk("result", ores[d], e.res);
            chk("tag", otag[d], e.tag);
            chk("zero", oz[d], e.zero);
            chk("illegal", oi[d], e.ill);
            if (e.lat) chk("latency", cyc - e.acc, stg[d] - 1);
          end
        end
      end
    end
  end

  task automatic offer(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [4:0] tag, input bit lat,
                       output bit acc);
    ia[d]   = a;
    ib[d]   = b;
    iop[d]  = op;
    itag[d] = tag;
    iv[d]   = 1'b1;
    @(negedge clk);
    acc = ir[d];
    if (acc) sb.push_back(model(d, a, b, op, tag, cyc + 1, lat));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] tag);
    bit acc;
    int n;
    n = 0;
    do begin
      offer(d, a, b, op, tag, 1'b1, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", ir[d], 1);
  endtask

  task automatic idle(input int d, input int n);
    iv[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_amt();
    case ($urandom_range(3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(31));
      2:       return 32'(32 + $urandom_range(100));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] rand_op();
    if ($urandom_range(9) < 8) return 3'($urandom_range(4));
    return 3'(5 + $urandom_range(2));
  endfunction

  task automatic rand_run(input int d, input int n, input bit bp);
    int sent;
    int cycles;
    bit acc;
    sent   = 0;
    cycles = 0;
    while (sent < n && cycles < 20 * n) begin
      ordy[d] = bp ? ($urandom_range(2) != 0) : 1'b1;
      if ($urandom_range(3) != 0) begin
        offer(d, 32'($urandom), rand_amt(), rand_op(), 5'($urandom), !bp, acc);
        if (acc) sent++;
      end else begin
        iv[d] = 1'b0;
        @(posedge clk);
        #1;
      end
      cycles++;
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
  endtask

  task automatic directed(input int d);
    send(d, 32'h0000_0001, 32'd31,      OP_SLL, 5'd7);
    send(d, 32'hFFFF_FFFF, 32'd32,      OP_SLL, 5'd1);
    send(d, 32'hFFFF_FFFF, 32'h1_0000,  OP_SRL, 5'd2);
    send(d, 32'h8000_0000, 32'd40,      OP_SRA, 5'd4);
    send(d, 32'h4000_0000, 32'd40,      OP_SRA, 5'd5);
    send(d, 32'h8000_0001, 32'd33,      OP_ROL, 5'd6);
    send(d, 32'h0000_0003, 32'd1,       OP_ROR, 5'd8);
    send(d, 32'h1234_5678, 32'd0,       OP_ROR, 5'd9);
    send(d, 32'hDEAD_BEEF, 32'd0,       OP_SRA, 5'd10);
    send(d, 32'h8765_4321, 32'd31,      OP_SRA, 5'd12);
    send(d, 32'h0000_ABCD, 32'd5,       3'b110, 5'd3);
    idle(d, 1);
    drain();
  endtask

  task automatic stream_bp();
    logic [31:0] sa[4];
    logic [31:0] sbv[4];
    logic [2:0]  sop[4];
    bit acc;
    int i;
    int c;
    sa  = '{32'h0000_00F0, 32'hF000_0000, 32'h8000_0000, 32'h0000_0011};
    sbv = '{32'd4, 32'd8, 32'd3, 32'd36};
    sop = '{OP_SLL, OP_SRL, OP_SRA, OP_ROL};
    i = 0;
    c = 0;
    while (i < 4 && c < 50) begin
      ordy[0] = !(c >= 2 && c < 5);
      offer(0, sa[i], sbv[i], sop[i], 5'(20 + i), 1'b0, acc);
      if (acc) i++;
      c++;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    chk("stream_sent", i, 4);
    drain();
  endtask

  task automatic rst_mid(input int d);
    bit acc;
    offer(d, 32'h0000_1234, 32'd4, OP_SLL, 5'd11, 1'b0, acc);
    offer(d, 32'h0000_F0F0, 32'd3, OP_ROR, 5'd12, 1'b0, acc);
    iv[d] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", ov[d], 0);
    chk("rst_result", ores[d], 0);
    chk("rst_tag", otag[d], 0);
    chk("rst_in_ready", ir[d], 1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_stale", ov[d], 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      ia[d]   = '0;
      ib[d]   = '0;
      iop[d]  = '0;
      itag[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", ov[d], 0);
      chk("reset_result", ores[d], 0);
      chk("reset_tag", otag[d], 0);
      chk("reset_flags", {oz[d], oi[d]}, 0);
      chk("reset_in_ready", ir[d], 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed(0);
    stream_bp();
    rand_run(0, 300, 1'b1);
    rand_run(0, 100, 1'b0);
    drain();
    rst_mid(0);
    directed(0);

    for (int d = 1; d < 3; d++) begin
      directed(d);
      rand_run(d, 100, 1'b0);
      rand_run(d, 60, 1'b1);
      drain();
      rst_mid(d);
      send(d, 32'hA5A5_0001, 32'd35, OP_ROR, 5'd30);
      idle(d, 1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
